// File: rtl/pipo_decrypt_core_pkg.sv
// -----------------------------------------------------------------------------
// pipo_decrypt_core_pkg
// Shared types and helpers for the PIPO-64/128 decryption core.
//   state_t   : 64-bit cipher state. Byte j = bits [8j+7:8j] is bit-slice row j.
//   key_t     : 128-bit master key. K0 = key[63:0], K1 = key[127:64].
//   fsm_t     : control states of the core.
//   row_rot() : per-row left-rotation amount used by the forward R-layer.
//   rotr8()   : 8-bit rotate right.
//   rk()      : round key RK_i = K_(i mod 2) ^ {56'b0, i}.
// -----------------------------------------------------------------------------
package pipo_decrypt_core_pkg;

    localparam int NUM_ROUNDS = 13;

    typedef logic [63:0]  state_t;
    typedef logic [127:0] key_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } fsm_t;

    // Left-rotation amounts of the forward R-layer, one per byte row.
    // The inverse layer rotates right by the same amounts.
    function automatic logic [2:0] row_rot(input int row);
        logic [2:0] amt;
        case (row)
            1:       amt = 3'd7;
            2:       amt = 3'd4;
            3:       amt = 3'd3;
            4:       amt = 3'd6;
            5:       amt = 3'd5;
            6:       amt = 3'd1;
            7:       amt = 3'd2;
            default: amt = 3'd0;
        endcase
        return amt;
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] b, input logic [2:0] n);
        logic [15:0] d;
        d = {b, b} >> n;
        return d[7:0];
    endfunction

    // Even rounds use the low key half, odd rounds the high half; the round
    // index is folded into the least significant byte.
    function automatic state_t rk(input key_t k, input logic [7:0] rnd);
        state_t base;
        base = rnd[0] ? k[127:64] : k[63:0];
        return base ^ {56'b0, rnd};
    endfunction

endpackage

// File: rtl/pipo_decrypt_core_inv_round.sv
// -----------------------------------------------------------------------------
// pipo_inv_round
// One combinational PIPO inverse round: blk_out = Sinv(Rinv(blk_in)) ^ round_key.
//   blk_in    : 64-bit state entering the round
//   round_key : 64-bit round key applied after the inverse layers
//   blk_out   : 64-bit state leaving the round
// -----------------------------------------------------------------------------
module pipo_inv_round
    import pipo_decrypt_core_pkg::*;
(
    input  logic [63:0] blk_in,
    input  logic [63:0] round_key,
    output logic [63:0] blk_out
);

    function automatic state_t rinv_layer(input state_t x);
        state_t y;
        y = '0;
        for (int j = 0; j < 8; j++) begin
            y[8*j +: 8] = rotr8(x[8*j +: 8], row_rot(j));
        end
        return y;
    endfunction

    // Inverse of the bit-sliced 8-bit S-box: every byte row is one bit of the
    // S-box input across all eight columns. Forward steps are undone in reverse
    // order; the final output permutation of the forward layer is unwound first
    // by naming the rows it produced.
    function automatic state_t sinv_layer(input state_t y);
        logic [7:0] x0, x1, x2, x3, x4, x5, x6, x7;
        logic [7:0] a, b, c;
        logic [7:0] t0f, t1f, t2f, x5_0, x6_0, x6_1;

        // Rows that passed through S5_2 only as copied operands.
        a = y[7:0];      // x7 entering S5_2
        b = y[55:48];    // x3 entering S5_2
        c = y[47:40];    // x4 entering S5_2

        // Undo S5_2, recovering its x5/x6 inputs and the final temporaries.
        x5_0 = y[39:32] ^ (y[31:24] | c);
        x6_1 = y[31:24] ^ (c | b);
        t0f  = a ^ x6_1;
        t1f  = b ^ x5_0;
        t2f  = c ^ (t1f & t0f);
        x6_0 = x6_1 ^ (a & x5_0);

        // Undo the truncated XOR into the S3 rows.
        x0 = y[15:8]  ^ t1f;
        x2 = y[23:16] ^ t0f;
        x1 = y[63:56] ^ t2f;
        x5 = x5_0;
        x6 = x6_0;

        // Undo the extended XOR.
        x7 = a ^ x1;
        x3 = b ^ x2;
        x4 = c ^ x0;

        // Undo S3.
        x2 = ~x2;
        x1 = x1 ^ (x2 | x0);
        x0 = x0 ^ (x2 | x1);
        x2 = x2 ^ (x1 & x0);

        // Undo S5_1.
        x4 = x4 ^ (x5 & x6);
        x5 = x5 ^ x7;
        x3 = x3 ^ (x4 | x5);
        x6 = x6 ^ x3;
        x7 = x7 ^ x4;
        x4 = x4 ^ (x3 & x5);
        x5 = x5 ^ (x7 & x6);

        return {x7, x6, x5, x4, x3, x2, x1, x0};
    endfunction

    assign blk_out = sinv_layer(rinv_layer(blk_in)) ^ round_key;

endmodule

// File: rtl/pipo_decrypt_core.sv
// -----------------------------------------------------------------------------
// pipo_decrypt_core
// Iterative PIPO-64/128 decryption, one inverse round per clock.
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   in_valid   : ciphertext/key offered
//   in_ready   : core can accept a block (IDLE only)
//   ciphertext : 64-bit block to decrypt
//   key        : 128-bit master key
//   out_valid  : plaintext valid, held until out_ready
//   out_ready  : consumer accepts plaintext
//   plaintext  : decrypted block, 0 when out_valid is low
//   busy       : high while a block is in flight (ROUND or DONE)
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for a block; in_ready high
//   ST_ROUND | applying inverse rounds, rnd counts NUM_ROUNDS down to 1
//   ST_DONE  | plaintext presented, waiting for out_ready
// -----------------------------------------------------------------------------
module pipo_decrypt_core #(
    parameter int NUM_ROUNDS = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  plaintext,
    output logic         busy
);

    import pipo_decrypt_core_pkg::state_t;
    import pipo_decrypt_core_pkg::key_t;
    import pipo_decrypt_core_pkg::fsm_t;
    import pipo_decrypt_core_pkg::ST_IDLE;
    import pipo_decrypt_core_pkg::ST_ROUND;
    import pipo_decrypt_core_pkg::ST_DONE;
    import pipo_decrypt_core_pkg::rk;

    localparam int RND_W = $clog2(NUM_ROUNDS + 1);

    fsm_t             fsm_q, fsm_d;
    state_t           blk_q;
    key_t             key_q;
    logic [RND_W-1:0] rnd_q;
    logic [RND_W-1:0] rnd_m1;
    state_t           round_key;
    state_t           round_out;

    // Saturating so the key index never wraps; rnd is never 0 in ROUND anyway.
    assign rnd_m1    = (rnd_q == '0) ? '0 : rnd_q - 1'b1;
    assign round_key = rk(key_q, 8'(rnd_m1));

    pipo_inv_round u_inv_round (
        .blk_in    (blk_q),
        .round_key (round_key),
        .blk_out   (round_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE:  if (in_valid)             fsm_d = ST_ROUND;
            ST_ROUND: if (rnd_q <= RND_W'(1))   fsm_d = ST_DONE;
            ST_DONE:  if (out_ready)            fsm_d = ST_IDLE;
            default:                            fsm_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        plaintext = '0;
        case (fsm_q)
            ST_IDLE:  in_ready = 1'b1;
            ST_ROUND: busy     = 1'b1;
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                plaintext = blk_q;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Key is captured at accept so the inputs are free to change during ROUND.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_q <= '0;
            key_q <= '0;
            rnd_q <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        key_q <= key;
                        blk_q <= ciphertext ^ rk(key, 8'(NUM_ROUNDS));
                        rnd_q <= RND_W'(NUM_ROUNDS);
                    end
                end
                ST_ROUND: begin
                    blk_q <= round_out;
                    if (rnd_q != '0) begin
                        rnd_q <= rnd_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipo_decrypt_core.sv
module tb_pipo_decrypt_core;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  ciphertext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  plaintext;
    logic         busy;

    localparam logic [127:0] KAT_KEY = 128'h6DC416DD_779428D2_7E1D20AD_2E152297;
    localparam logic [63:0]  KAT_CT  = 64'h6B6B2981_AD5D0327;
    localparam logic [63:0]  KAT_PT  = 64'h098552F6_1E270026;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sbox_tab [256];
    int         rot [8] = '{0, 7, 4, 3, 6, 5, 1, 2};

    pipo_decrypt_core #(.NUM_ROUNDS(13)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: forward PIPO encryption ----------------
    // Scalar 8-bit S-box of the existing encryption datapath (bit 7 = row 7).
    function automatic logic [7:0] sbox_eval(input logic [7:0] v);
        logic [7:0] x;
        logic t0, t1, t2, n0;
        x = v;
        x[5] ^= x[7] & x[6];
        x[4] ^= x[3] & x[5];
        x[7] ^= x[4];
        x[6] ^= x[3];
        x[3] ^= x[4] | x[5];
        x[5] ^= x[7];
        x[4] ^= x[5] & x[6];
        x[2] ^= x[1] & x[0];
        x[0] ^= x[2] | x[1];
        x[1] ^= x[2] | x[0];
        x[2] = ~x[2];
        x[7] ^= x[1];
        x[3] ^= x[2];
        x[4] ^= x[0];
        t0 = x[7]; t1 = x[3]; t2 = x[4];
        x[6] ^= t0 & x[5];
        t0 ^= x[6];
        x[6] ^= t2 | t1;
        t1 ^= x[5];
        x[5] ^= x[6] | t2;
        t2 ^= t1 & t0;
        x[2] ^= t0;
        n0 = x[1] ^ t2;
        x[1] = x[0] ^ t1;
        x[0] = x[7];
        x[7] = n0;
        t1 = x[3]; x[3] = x[6]; x[6] = t1;
        t2 = x[4]; x[4] = x[5]; x[5] = t2;
        return x;
    endfunction

    function automatic logic [63:0] s_model(input logic [63:0] x);
        logic [63:0] y;
        logic [7:0]  col, o;
        y = '0;
        for (int bcol = 0; bcol < 8; bcol++) begin
            for (int j = 0; j < 8; j++) col[j] = x[8*j + bcol];
            o = sbox_tab[col];
            for (int j = 0; j < 8; j++) y[8*j + bcol] = o[j];
        end
        return y;
    endfunction

    function automatic logic [63:0] r_model(input logic [63:0] x);
        logic [63:0] y;
        logic [15:0] d;
        logic [7:0]  bv;
        y = '0;
        for (int j = 0; j < 8; j++) begin
            bv = x[8*j +: 8];
            d  = {bv, bv} << rot[j];
            y[8*j +: 8] = d[15:8];
        end
        return y;
    endfunction

    function automatic logic [63:0] rk_model(input logic [127:0] k, input int i);
        logic [63:0] base;
        base = (i % 2 == 1) ? k[127:64] : k[63:0];
        return base ^ 64'(i);
    endfunction

    function automatic logic [63:0] enc_model(input logic [63:0] p, input logic [127:0] k);
        logic [63:0] x;
        x = p ^ rk_model(k, 0);
        for (int i = 1; i <= 13; i++) x = r_model(s_model(x)) ^ rk_model(k, i);
        return x;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Offer a block and return right after the accept edge.
    task automatic start_block(input logic [127:0] k, input logic [63:0] c);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        key        = k;
        ciphertext = c;
        step();
        in_valid = 1'b0;
    endtask

    // Wait for out_valid; optionally scramble the inputs every cycle meanwhile.
    task automatic wait_out(input logic [63:0] exp, input string tag, input bit scramble);
        int n;
        bit busy_low;
        n = 0;
        busy_low = 1'b0;
        while (!out_valid && n < 40) begin
            if (!busy) busy_low = 1'b1;
            if (scramble) begin
                key        = rand128();
                ciphertext = rand64();
                in_valid   = 1'($urandom_range(0, 1));
            end
            step();
            n++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 64'(n), 64'd13);
        chk({tag, "_busy_low"}, 64'(busy_low), 64'd0);
        chk({tag, "_pt"}, plaintext, exp);
    endtask

    initial begin
        logic [63:0]  p, c;
        logic [127:0] k;
        logic [63:0]  bk_p [3];
        logic [63:0]  bk_c [3];
        logic [127:0] bk_k [3];
        int           acc_at [$];
        logic [63:0]  got [$];
        int           idx;
        bit           pend;
        bit           seen;

        for (int v = 0; v < 256; v++) sbox_tab[v] = sbox_eval(8'(v));

        // Reset, with in_valid high: reset must win.
        reset      = 1'b1;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        key        = KAT_KEY;
        ciphertext = KAT_CT;
        repeat (3) step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_plaintext", plaintext, 64'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("rst_nothing_accepted", 64'(busy), 64'd0);

        // Known-answer test.
        out_ready = 1'b1;
        start_block(KAT_KEY, KAT_CT);
        wait_out(KAT_PT, "kat", 1'b0);
        step();
        chk("kat_ov_one_cycle", 64'(out_valid), 64'd0);
        chk("kat_in_ready_after", 64'(in_ready), 64'd1);
        chk("kat_pt_zero_idle", plaintext, 64'd0);

        // Backpressure.
        out_ready = 1'b0;
        start_block(KAT_KEY, KAT_CT);
        wait_out(KAT_PT, "bp", 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid   = 1'(i % 2);
            ciphertext = rand64();
            key        = rand128();
            step();
            chk("bp_ov_held", 64'(out_valid), 64'd1);
            chk("bp_pt_held", plaintext, KAT_PT);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_ov", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_busy", 64'(busy), 64'd0);

        // Reset during ROUND cycle 6.
        start_block(KAT_KEY, KAT_CT);
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_ov", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_pt", plaintext, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_output", 64'(seen), 64'd0);
        start_block(KAT_KEY, KAT_CT);
        wait_out(KAT_PT, "midrst_kat", 1'b0);
        step();

        // Round-trip with random key/plaintext, inputs scrambled during ROUND.
        for (int i = 0; i < 200; i++) begin
            k = rand128();
            p = rand64();
            c = enc_model(p, k);
            start_block(k, c);
            wait_out(p, "rt", 1'b1);
            step();
        end

        // Back-to-back: in_valid held high over three queued blocks.
        for (int i = 0; i < 3; i++) begin
            bk_k[i] = rand128();
            bk_p[i] = rand64();
            bk_c[i] = enc_model(bk_p[i], bk_k[i]);
        end
        idx        = 0;
        pend       = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        key        = bk_k[0];
        ciphertext = bk_c[0];
        for (int cyc = 0; cyc < 100 && got.size() < 3; cyc++) begin
            if (pend) begin
                pend = 1'b0;
                idx++;
                if (idx < 3) begin
                    key        = bk_k[idx];
                    ciphertext = bk_c[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (in_valid && in_ready) begin
                acc_at.push_back(cyc);
                pend = 1'b1;
            end
            if (out_valid) got.push_back(plaintext);
            step();
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 64'(acc_at.size()), 64'd3);
        if (acc_at.size() == 3) begin
            chk("b2b_spacing_1", 64'(acc_at[1] - acc_at[0]), 64'd15);
            chk("b2b_spacing_2", 64'(acc_at[2] - acc_at[1]), 64'd15);
        end
        chk("b2b_outputs", 64'(got.size()), 64'd3);
        for (int i = 0; i < got.size() && i < 3; i++) begin
            chk("b2b_pt", got[i], bk_p[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
